// File: rtl/aes_256_dec_iter.sv
// Iterative AES-256 decryptor: forward key expansion to w52..w59, then 14 inverse rounds
// with an on-the-fly reverse key schedule. Optional key cache: AES_DEC_KEY_CACHE_EN.
module aes_256_dec_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [255:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [2:0] {IDLE, KEYEXP, ARK, ROUND, DONE} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int k = 1; k < 8; k++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = gf_inv(a);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] a;
      a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   state_e             st_q, st_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [127:0]       s_q, s_d;
   logic [0:7][31:0]   k_q, k_d;
   logic [127:0]       out_state_q, out_state_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
   logic               cache_vld_q, cache_vld_d;
   logic [255:0]       cache_key_q, cache_key_d;
   logic [0:7][31:0]   cache_win_q, cache_win_d;
`endif

   // One SubWord serves both directions: forward expansion taps K[7], the reverse step taps K[3].
   // Odd cnt (forward) and odd r (reverse) are exactly the RotWord/rcon half-steps.
   logic [31:0] sw_in, sw_pre, sw_out;
   logic [3:0]  rc_idx;
   logic [7:0]  rc;
   logic [31:0] n0, n1, n2, n3, p0, p1, p2, p3;
   logic [127:0] rk_lo, rk_hi, isb, ark_v, imc;

   assign sw_in  = (st_q == KEYEXP) ? k_q[7] : k_q[3];
   assign sw_pre = cnt_q[0] ? {sw_in[23:0], sw_in[31:24]} : sw_in;
   assign rc_idx = (cnt_q + 4'd1) >> 1;
   assign rc     = cnt_q[0] ? (8'h01 << (rc_idx - 4'd1)) : 8'h00;
   assign sw_out = sub_word(sw_pre) ^ {rc, 24'h000000};

   assign n0 = k_q[0] ^ sw_out;
   assign n1 = k_q[1] ^ n0;
   assign n2 = k_q[2] ^ n1;
   assign n3 = k_q[3] ^ n2;

   assign p0 = k_q[4] ^ sw_out;
   assign p1 = k_q[5] ^ k_q[4];
   assign p2 = k_q[6] ^ k_q[5];
   assign p3 = k_q[7] ^ k_q[6];

   assign rk_lo = {k_q[0], k_q[1], k_q[2], k_q[3]};
   assign rk_hi = {k_q[4], k_q[5], k_q[6], k_q[7]};
   assign isb   = inv_sub_bytes(inv_shift_rows(s_q));
   assign ark_v = isb ^ rk_lo;
   assign imc   = inv_mix_columns(ark_v);

   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q;
      s_d         = s_q;
      k_d         = k_q;
      out_state_d = out_state_q;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_vld_d = cache_vld_q;
      cache_key_d = cache_key_q;
      cache_win_d = cache_win_q;
`endif
      case (st_q)
         IDLE: begin
            if (in_valid) begin
               s_d   = in_state;
               k_d   = in_key;
               cnt_d = 4'd1;
               st_d  = KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
               if (cache_vld_q && (in_key == cache_key_q)) begin
                  k_d  = cache_win_q;
                  st_d = ARK;
               end else begin
                  cache_vld_d = 1'b0;
                  cache_key_d = in_key;
               end
`endif
            end
         end
         KEYEXP: begin
            k_d   = {k_q[4], k_q[5], k_q[6], k_q[7], n0, n1, n2, n3};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd13) begin
               st_d = ARK;
`ifdef AES_DEC_KEY_CACHE_EN
               cache_win_d = {k_q[4], k_q[5], k_q[6], k_q[7], n0, n1, n2, n3};
               cache_vld_d = 1'b1;
`endif
            end
         end
         ARK: begin
            s_d   = s_q ^ rk_hi;
            cnt_d = 4'd13;
            st_d  = ROUND;
         end
         ROUND: begin
            if (cnt_q != 4'd0) begin
               s_d   = imc;
               k_d   = {p0, p1, p2, p3, k_q[0], k_q[1], k_q[2], k_q[3]};
               cnt_d = cnt_q - 4'd1;
            end else begin
               s_d         = ark_v;
               out_state_d = ark_v;
               st_d        = DONE;
            end
         end
         DONE: begin
            if (out_ready) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
      in_ready_d  = (st_d == IDLE);
      out_valid_d = (st_d == DONE);
      busy_d      = (st_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= IDLE;
         cnt_q       <= 4'd0;
         s_q         <= '0;
         k_q         <= '0;
         out_state_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
         cache_vld_q <= 1'b0;
         cache_key_q <= '0;
         cache_win_q <= '0;
`endif
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         s_q         <= s_d;
         k_q         <= k_d;
         out_state_q <= out_state_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
         cache_vld_q <= cache_vld_d;
         cache_key_q <= cache_key_d;
         cache_win_q <= cache_win_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_state = out_state_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes_256_dec_iter.sv
// Bench for aes_256_dec_iter: known-answer vectors plus random blocks produced by a
// table-driven AES-256 encryptor model; latency tracked with a key-cache model.
module tb_aes_256_dec_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [255:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   aes_256_dec_iter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_state (in_state),
      .in_key   (in_key),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_state(out_state),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb [256];
   logic [255:0] m_key;
   bit           m_vld = 1'b0;

   localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] P_C3 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] C_SP1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
   localparam logic [127:0] P_SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C_SP2 = 128'h591ccb10d410ed26dc5ba74a31362870;
   localparam logic [127:0] P_SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

   function automatic logic [7:0] m_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = m_xt(x);
      end
      return p;
   endfunction

   // S-box built by brute-force inverse search followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] cst;
      logic [7:0] o;
      cst = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 0;
         for (int b = 1; b < 256; b++)
            if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
         sb[a] = o;
      end
   endtask

   function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [255:0] key);
      logic [31:0] w [60];
      logic [7:0]  st [16];
      logic [7:0]  t [16];
      logic [31:0] tmp;
      logic [7:0]  rc;
      logic [7:0]  a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         tmp = w[i-1];
         if (i % 8 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc = m_xt(rc);
         end else if (i % 8 == 4) begin
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
         end
         w[i] = w[i-8] ^ tmp;
      end
      for (int b = 0; b < 16; b++) st[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
      for (int rnd = 1; rnd <= 14; rnd++) begin
         for (int b = 0; b < 16; b++) st[b] = sb[st[b]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = st[r+4*((c+r)%4)];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rnd < 14) begin
               st[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
               st[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
               st[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
               st[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
            end else begin
               st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
            end
         end
         for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*rnd+b/4][31-8*(b%4) -: 8];
      end
      res = '0;
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
      return res;
   endfunction

   function automatic int exp_lat(input logic [255:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
      if (m_vld && key == m_key) return 15;
`endif
      return 28;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction: accept, measure latency, compare, optional backpressure, drain.
   task automatic run_txn(input string tag, input logic [255:0] key, input logic [127:0] ct,
                          input logic [127:0] pt, input int hold);
      int lat;
      int el;
      el = exp_lat(key);
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_key   = key;
      in_state = ct;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 256'(lat), 256'(el));
      chk({tag, "_plaintext"}, out_state, pt);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_state = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {8{$urandom}};
         chk({tag, "_hold_state"}, out_state, pt);
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_ready"}, in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_drain_valid"}, out_valid, 0);
      chk({tag, "_drain_ready"}, in_ready, 1);
      chk({tag, "_drain_busy"}, busy, 0);
      m_key = key;
      m_vld = 1'b1;
   endtask

   initial begin
      logic [255:0] rkey;
      logic [127:0] rpt;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      in_key    = '0;
      out_ready = 1'b0;
      build_sbox();
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_state", out_state, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn("c3", K_C3, C_C3, P_C3, 0);
      run_txn("sp1_bp", K_SP, C_SP1, P_SP1, 5);
      run_txn("sp2_b2b", K_SP, C_SP2, P_SP2, 0);

      // Abort a C.3 decryption mid-round with reset.
      @(negedge clk);
      in_valid = 1'b1;
      in_key   = K_C3;
      in_state = C_C3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_out_state", out_state, 0);
      m_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_txn("c3_after_abort", K_C3, C_C3, P_C3, 0);

      run_txn("alt_sp1", K_SP, C_SP1, P_SP1, 0);
      run_txn("alt_c3", K_C3, C_C3, P_C3, 0);
      run_txn("alt_sp2", K_SP, C_SP2, P_SP2, 0);
      run_txn("alt_c3b", K_C3, C_C3, P_C3, 0);

      for (int i = 0; i < 3; i++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         for (int j = 0; j < 2; j++) begin
            rpt = {$urandom, $urandom, $urandom, $urandom};
            run_txn("rand", rkey, model_enc(rpt, rkey), rpt, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_256_dec_iter.md
Name: aes_256_dec_iter

Overview:
- Iterative AES-256 decryptor: the inverse-direction companion to the pipelined AES-256 encryptor.
- Accepts one 128-bit ciphertext and 256-bit key per transaction over a valid/ready handshake.
- Expands the key forward to the last round-key window, then runs 14 inverse rounds while stepping the key schedule backwards on the fly, one round per clock.
- Area-lean counterpart for receive paths that do not need full throughput.

Parameters:
- none.
- Round count fixed at 14; rcon sequence fixed: 01,02,04,08,10,20,40.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  ciphertext/key present
- in_ready  out  1  block can accept
- in_state  in  128  ciphertext; [127:120] = byte 0
- in_key  in  256  cipher key; [255:224] = w0 … [31:0] = w7
- out_valid  out  1  plaintext present
- out_ready  in  1  sink accepts plaintext
- out_state  out  128  plaintext, same byte order
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by the system): state machine = IDLE, in_ready=1, out_valid=0, out_state=0, busy=0, round/step counter=0, internal state and key window cleared. Reset mid-transaction aborts it with no output.
- Key window: 8 words K[0..7]; rk_lo = K[0..3], rk_hi = K[4..7].
- FSM states: IDLE, KEYEXP, ARK, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_state and in_key (K=w0..w7); cnt=1; go to KEYEXP.
- KEYEXP: 13 cycles. Each cycle performs one forward half-step: K ← {K[4..7], n0..n3}.
  - Odd cnt (type A), rcon=RC[(cnt+1)/2]: n0 = K[0] ^ SubWord(RotWord(K[7])) ^ {rcon,24'h0}.
  - Even cnt (type B): n0 = K[0] ^ SubWord(K[7]).
  - Both types: n1=K[1]^n0, n2=K[2]^n1, n3=K[3]^n2.
  - After cnt=13, K = w52..w59; go to ARK.
- ARK: 1 cycle. S ← S ^ rk_hi (round key 14); r=13; go to ROUND.
- ROUND: 14 cycles.
  - r=13..1: S ← InvMixColumns(InvSubBytes(InvShiftRows(S)) ^ rk_lo). In the same cycle the key window takes one reverse half-step K ← {p0..p3, K[0..3]}:
    - p3=K[7]^K[6]; p2=K[6]^K[5]; p1=K[5]^K[4].
    - Window start s≡4 mod 8: p0 = K[4] ^ SubWord(RotWord(K[3])) ^ {RC[(s+4)/8],24'h0}.
    - Otherwise: p0 = K[4] ^ SubWord(K[3]).
    - s starts at 52 and decreases by 4 each step.
  - r=0: S ← InvSubBytes(InvShiftRows(S)) ^ rk_lo, with rk_lo = w0..w3; no key step. Load out_state; go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_state held stable while out_ready=0.
  - On out_ready: out_valid←0 next edge; go to IDLE.
- Latency: out_valid rises exactly 28 clocks after the accepting edge. Throughput: one block per ≥29 cycles.
- in_valid is ignored outside IDLE.
- The S-box and inverse S-box are combinational byte functions; no registered lookups inside the round loop.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- Defined:
  - Block retains the last in_key and its w52..w59 window with a valid flag; the flag is cleared by reset.
  - On accept, if valid and in_key equals the cached key, load K from cache and go straight to ARK. Latency = 15.
  - Otherwise run KEYEXP and refresh the cache on its completion.
  - An aborted transaction (reset) leaves the cache invalid.
- Undefined: no cache storage; latency always 28.

Test Plan:
- FIPS-197 C.3: key 000102…1e1f, ct 8ea2b7ca516745bfeafc49904b496089 -> out_state 00112233445566778899aabbccddeeff; out_valid 28 clocks after accept.
- SP800-38A ECB-AES256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, ct f3eed1bdb5d2a03c064b5a7e3db181f8 -> 6bc1bee22e409f96e93d7e117393172a.
- Backpressure: out_ready held low 5 cycles after out_valid -> out_state stable, in_ready=0, in_valid pulses ignored; first out_ready high -> out_valid low next cycle.
- Back-to-back, same SP800-38A key: second ct 591ccb10d410ed26dc5ba74a31362870 -> ae2d8a571e03ac9c9eb76fac45af8e51. Latency 15 with AES_DEC_KEY_CACHE_EN, 28 without.
- rst_n pulsed low during ROUND (r=7) -> outputs return to reset values immediately; no out_valid; the next C.3 transaction decrypts correctly with full latency 28, including with AES_DEC_KEY_CACHE_EN.
- Key-change check: alternate C.3 and SP800-38A keys -> all correct; with the cache enabled, no transaction completes in 15 cycles.
